// File: rtl/lsu_subword_adapter.sv
// ---------------------------------------------------------------------------
// lsu_subword_adapter
//
// Sits between the pipeline memory stage and the data-memory interface.
// Every access to memory is a single aligned 32-bit word:
//   - word loads/stores pass straight through
//   - sub-word loads read the word, then select a lane and extend it
//   - sub-word stores read the word, merge the new lane and write it back
// The pipeline is held through lsu_stall while a sequence is running.
// Misaligned requests are rejected with a one-cycle misaligned pulse.
//
// Ports
//   clock, reset      rising-edge clock, asynchronous active-high reset
//   req_load/store    request strobes, held by the pipeline under stall
//   req_size          00 byte, 01 half, 1x word
//   req_unsigned      1 = zero-extend loads, 0 = sign-extend
//   req_addr          byte address
//   req_data          store data, right-justified
//   lsu_stall         pipeline hold (combinational)
//   load_data         extended load result, held until the next load
//   load_valid        one-cycle pulse, load result valid
//   store_done        one-cycle pulse, store committed
//   misaligned        one-cycle pulse, request rejected
//   mem_read/write    one-cycle memory strobes, never together
//   mem_address       word address, held between accesses
//   mem_in_data       word written to memory
//   mem_out_data      word read from memory, valid the cycle after mem_read
//   report            trace enable for simulation wrappers
// ---------------------------------------------------------------------------
//  state   | meaning
//  IDLE    | waiting for a request; accepts or rejects it
//  RD      | mem_read asserted for the target word
//  RD_WAIT | read word arrives: extract lane (load) or merge lane (store)
//  WR      | mem_write asserted with the full word
//  RESP    | load_valid or store_done pulse; pipeline released
// ---------------------------------------------------------------------------
module lsu_subword_adapter #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDRESS_BITS = 20,
   parameter int CORE         = 0
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    req_load,
   input  logic                    req_store,
   input  logic [1:0]              req_size,
   input  logic                    req_unsigned,
   input  logic [ADDRESS_BITS-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0]   req_data,
   output logic                    lsu_stall,
   output logic [DATA_WIDTH-1:0]   load_data,
   output logic                    load_valid,
   output logic                    store_done,
   output logic                    misaligned,
   output logic                    mem_read,
   output logic                    mem_write,
   output logic [ADDRESS_BITS-1:0] mem_address,
   output logic [DATA_WIDTH-1:0]   mem_in_data,
   input  logic [DATA_WIDTH-1:0]   mem_out_data,
   input  logic                    report
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD      = 3'd1,
      RD_WAIT = 3'd2,
      WR      = 3'd3,
      RESP    = 3'd4
   } state_t;

   state_t state, state_next;

   logic        req_valid;
   logic        req_mis;
   logic        accept;

   // request fields latched at accept; only the byte offset and the low
   // half of the store data are needed after that
   logic [1:0]  lane_q;
   logic [1:0]  size_q;
   logic        uns_q;
   logic        store_q;
   logic [15:0] data_q;

   logic [7:0]            rd_byte;
   logic [15:0]           rd_half;
   logic [DATA_WIDTH-1:0] rd_ext;
   logic [DATA_WIDTH-1:0] merged;

   logic                    mem_read_d;
   logic                    mem_write_d;
   logic [ADDRESS_BITS-1:0] mem_address_d;
   logic [DATA_WIDTH-1:0]   mem_in_data_d;
   logic [DATA_WIDTH-1:0]   load_data_d;
   logic                    load_valid_d;
   logic                    store_done_d;
   logic                    misaligned_d;

   // trace hook is consumed by simulation wrappers, not by the datapath
   logic unused_debug;
   assign unused_debug = report & (CORE >= 0);

   assign req_valid = req_load | req_store;

   always_comb begin
      case (req_size)
         2'b00:   req_mis = 1'b0;
         2'b01:   req_mis = req_addr[0];
         default: req_mis = (req_addr[1:0] != 2'b00);
      endcase
   end

   assign accept = (state == IDLE) && req_valid && !req_mis;

   // ---- state register ----
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // ---- next state ----
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept) begin
               // store wins over load; only full-word stores skip the read
               if (req_store && req_size[1]) state_next = WR;
               else                          state_next = RD;
            end
         end
         RD:      state_next = RD_WAIT;
         RD_WAIT: state_next = store_q ? WR : RESP;
         WR:      state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // ---- lane extract / merge on the returned word ----
   always_comb begin
      rd_byte = mem_out_data[{lane_q, 3'b000} +: 8];
      rd_half = mem_out_data[{lane_q[1], 4'b0000} +: 16];
      case (size_q)
         2'b00:   rd_ext = {{(DATA_WIDTH-8){~uns_q & rd_byte[7]}}, rd_byte};
         2'b01:   rd_ext = {{(DATA_WIDTH-16){~uns_q & rd_half[15]}}, rd_half};
         default: rd_ext = mem_out_data;
      endcase
   end

   always_comb begin
      merged = mem_out_data;
      if (size_q == 2'b00)
         merged[{lane_q, 3'b000} +: 8] = data_q[7:0];
      else if (size_q == 2'b01)
         merged[{lane_q[1], 4'b0000} +: 16] = data_q;
   end

   // ---- outputs ----
   always_comb begin
      lsu_stall     = accept || (state == RD) || (state == RD_WAIT) || (state == WR);
      mem_read_d    = (state_next == RD);
      mem_write_d   = (state_next == WR);
      mem_address_d = mem_address;
      mem_in_data_d = mem_in_data;
      load_data_d   = load_data;
      load_valid_d  = (state == RD_WAIT) && !store_q;
      store_done_d  = (state == WR);
      misaligned_d  = (state == IDLE) && req_valid && req_mis;

      if (accept) begin
         mem_address_d = {2'b00, req_addr[ADDRESS_BITS-1:2]};
         if (req_store && req_size[1]) mem_in_data_d = req_data;
      end
      if (state == RD_WAIT) begin
         if (store_q) mem_in_data_d = merged;
         else         load_data_d   = rd_ext;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mem_read    <= 1'b0;
         mem_write   <= 1'b0;
         mem_address <= '0;
         mem_in_data <= '0;
         load_data   <= '0;
         load_valid  <= 1'b0;
         store_done  <= 1'b0;
         misaligned  <= 1'b0;
         lane_q      <= 2'b00;
         size_q      <= 2'b00;
         uns_q       <= 1'b0;
         store_q     <= 1'b0;
         data_q      <= '0;
      end else begin
         mem_read    <= mem_read_d;
         mem_write   <= mem_write_d;
         mem_address <= mem_address_d;
         mem_in_data <= mem_in_data_d;
         load_data   <= load_data_d;
         load_valid  <= load_valid_d;
         store_done  <= store_done_d;
         misaligned  <= misaligned_d;
         if (accept) begin
            lane_q  <= req_addr[1:0];
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            store_q <= req_store;
            data_q  <= req_data[15:0];
         end
      end
   end

endmodule
